// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM init/refresh sequencer: command encodings,
// sequencer states, mode-register field layout and idle-bus constants.
// Optional feature macro used by sdram_ref_timer: SDRAM_REF_DEBT_EN.
package sdram_pkg;

    // {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_MRS   = 4'b0000;
    localparam logic [3:0] CMD_REF   = 4'b0001;

    typedef enum logic [3:0] {
        StWait,
        StPre,
        StPreW,
        StMrs,
        StMrsW,
        StAf,
        StAfW,
        StIdle,
        StRpre,
        StRpreW,
        StRaf,
        StRafW
    } state_t;

    // Mode-register field layout
    localparam int unsigned MR_BL_LSB  = 0;
    localparam int unsigned MR_BL_W    = 3;
    localparam int unsigned MR_BT_POS  = 3;
    localparam int unsigned MR_CAS_LSB = 4;
    localparam int unsigned MR_CAS_W   = 3;
    localparam int unsigned MR_WB_POS  = 9;
    localparam int unsigned MR_W       = 10;

    // Address/bank bits are filled with this value whenever no command needs them
    localparam logic       ADDR_IDLE_FILL = 1'b1;
    localparam logic [1:0] DQM_INIT       = 2'b11;
    localparam logic [1:0] DQM_RUN        = 2'b00;

    // Saturation point of the refresh debt counter
    localparam logic [3:0] REF_DEBT_MAX = 4'd8;

    function automatic logic [MR_W-1:0] mode_word(input logic [MR_CAS_W-1:0] cas,
                                                 input logic                bt,
                                                 input logic [MR_BL_W-1:0]  bl,
                                                 input logic                wb);
        logic [MR_W-1:0] w;
        w = '0;
        w[MR_BL_LSB +: MR_BL_W]   = bl;
        w[MR_BT_POS]              = bt;
        w[MR_CAS_LSB +: MR_CAS_W] = cas;
        w[MR_WB_POS]              = wb;
        return w;
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh interval timer with pending-refresh tracking and sticky miss flag.
// With SDRAM_REF_DEBT_EN defined, pending becomes a saturating 0..8 debt counter.
module sdram_ref_timer
    import sdram_pkg::*;
#(
    parameter int unsigned REF_INTERVAL = 780
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_consume,
    output logic o_ref_req,
    output logic o_ref_miss
);

    localparam int unsigned TW = (REF_INTERVAL > 2) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [TW-1:0] TCNT_WRAP = TW'(REF_INTERVAL - 1);

    logic [TW-1:0] r_tcnt;
    logic          w_tick;
    logic          r_req;
    logic          r_miss;
    logic          w_req_d;
    logic          w_miss_set;

    assign w_tick     = i_en && (r_tcnt == TCNT_WRAP);
    assign o_ref_req  = r_req;
    assign o_ref_miss = r_miss;

    // Free-running interval counter, held at zero until init completes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tcnt <= '0;
        end else if (!i_en || w_tick) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + TW'(1);
        end
    end

`ifdef SDRAM_REF_DEBT_EN
    logic [3:0] r_debt;
    logic [3:0] w_debt_d;

    // Tick adds one refresh of debt, consume removes one; both together cancel
    always_comb begin
        w_debt_d   = r_debt;
        w_miss_set = 1'b0;
        if (w_tick && !i_consume) begin
            if (r_debt == REF_DEBT_MAX) begin
                w_miss_set = 1'b1;
            end else begin
                w_debt_d = r_debt + 4'd1;
            end
        end else if (i_consume && !w_tick && (r_debt != 4'd0)) begin
            w_debt_d = r_debt - 4'd1;
        end
        w_req_d = (w_debt_d != 4'd0);
    end

    // Debt register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_debt <= '0;
        end else begin
            r_debt <= w_debt_d;
        end
    end
`else
    // Single pending bit; a tick on an already pending refresh is a lost deadline
    always_comb begin
        w_req_d    = r_req;
        w_miss_set = 1'b0;
        if (w_tick && !i_consume) begin
            w_miss_set = r_req;
            w_req_d    = 1'b1;
        end else if (i_consume && !w_tick) begin
            w_req_d = 1'b0;
        end
    end
`endif

    // Registered request and sticky miss outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req  <= 1'b0;
            r_miss <= 1'b0;
        end else begin
            r_req  <= w_req_d;
            r_miss <= r_miss | w_miss_set;
        end
    end

endmodule

// File: rtl/sdram_init_refresh.sv
// SDR SDRAM power-up sequencer and auto-refresh engine. Owns the command pins
// while busy=1; refreshes are issued only after a req/gnt handshake.
// Optional feature macro (in sdram_ref_timer): SDRAM_REF_DEBT_EN.
module sdram_init_refresh
    import sdram_pkg::*;
#(
    parameter int unsigned T_INIT       = 20000,
    parameter int unsigned T_RP         = 2,
    parameter int unsigned T_MRD        = 2,
    parameter int unsigned T_RC         = 7,
    parameter int unsigned INIT_AF_CNT  = 8,
    parameter int unsigned REF_INTERVAL = 780,
    parameter int unsigned ROW_W        = 13,
    parameter int unsigned BANK_W       = 2,
    parameter logic [2:0]  CAS_LAT      = 3'b011,
    parameter logic        BURST_TYPE   = 1'b0,
    parameter logic [2:0]  BL_CODE      = 3'b111,
    parameter logic        WB_MODE      = 1'b0
) (
    input  logic              REF_CLK,
    input  logic              RST_N,
    output logic              CKE,
    output logic              CS_N,
    output logic              RAS_N,
    output logic              CAS_N,
    output logic              WE_N,
    output logic [ROW_W-1:0]  A,
    output logic [BANK_W-1:0] BS,
    output logic [1:0]        DQM,
    output logic              init_done,
    output logic              busy,
    output logic              ref_req,
    input  logic              ref_gnt,
    output logic              ref_done,
    output logic              ref_miss
);

    localparam int unsigned CNT_MAX = max4(T_INIT, T_RP, T_MRD, T_RC);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Wait states are entered one cycle after their command, hence the -2
    localparam logic [CNT_W-1:0] C_INIT = CNT_W'(T_INIT);
    localparam logic [CNT_W-1:0] C_RP   = CNT_W'(T_RP - 2);
    localparam logic [CNT_W-1:0] C_MRD  = CNT_W'(T_MRD - 2);
    localparam logic [CNT_W-1:0] C_RC   = CNT_W'(T_RC - 2);
    // RPRE_W is entered together with the PRE command itself
    localparam logic [CNT_W-1:0] C_RRP  = CNT_W'(T_RP - 1);
    localparam logic [3:0]       C_AF   = 4'(INIT_AF_CNT);

    localparam logic [ROW_W-1:0]  A_IDLE  = {ROW_W{ADDR_IDLE_FILL}};
    localparam logic [BANK_W-1:0] BS_IDLE = {BANK_W{ADDR_IDLE_FILL}};
    localparam logic [ROW_W-1:0]  A_MODE  =
        ROW_W'(mode_word(CAS_LAT, BURST_TYPE, BL_CODE, WB_MODE));

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_af_cnt;
    logic              r_cke;
    logic [3:0]        r_cmd;
    logic [ROW_W-1:0]  r_a;
    logic [BANK_W-1:0] r_bs;
    logic [1:0]        r_dqm;
    logic              r_init_done;
    logic              r_busy;
    logic              r_ref_done;
    logic              r_consume;
    logic              w_ref_req;
    logic              w_ref_miss;

    assign CKE                      = r_cke;
    assign {CS_N, RAS_N, CAS_N, WE_N} = r_cmd;
    assign A                        = r_a;
    assign BS                       = r_bs;
    assign DQM                      = r_dqm;
    assign init_done                = r_init_done;
    assign busy                     = r_busy;
    assign ref_req                  = w_ref_req;
    assign ref_done                 = r_ref_done;
    assign ref_miss                 = w_ref_miss;

    // Sequencer FSM with registered pin outputs; pins default to NOP each cycle
    always_ff @(posedge REF_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= StWait;
            r_cnt       <= '0;
            r_af_cnt    <= '0;
            r_cke       <= 1'b0;
            r_cmd       <= CMD_DESEL;
            r_a         <= A_IDLE;
            r_bs        <= BS_IDLE;
            r_dqm       <= DQM_INIT;
            r_init_done <= 1'b0;
            r_busy      <= 1'b1;
            r_ref_done  <= 1'b0;
            r_consume   <= 1'b0;
        end else begin
            r_cke      <= 1'b1;
            r_cmd      <= CMD_NOP;
            r_a        <= A_IDLE;
            r_bs       <= BS_IDLE;
            r_ref_done <= 1'b0;
            r_consume  <= 1'b0;
            unique case (r_state)
                StWait: begin
                    if (r_cnt == C_INIT) begin
                        r_cnt   <= '0;
                        r_cmd   <= CMD_PRE;
                        r_state <= StPre;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StPre: begin
                    r_cnt   <= '0;
                    r_state <= StPreW;
                end
                StPreW: begin
                    if (r_cnt == C_RP) begin
                        r_cmd   <= CMD_MRS;
                        r_a     <= A_MODE;
                        r_bs    <= '0;
                        r_state <= StMrs;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StMrs: begin
                    r_cnt   <= '0;
                    r_state <= StMrsW;
                end
                StMrsW: begin
                    if (r_cnt == C_MRD) begin
                        r_cmd    <= CMD_REF;
                        r_af_cnt <= r_af_cnt + 4'd1;
                        r_state  <= StAf;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StAf: begin
                    r_cnt   <= '0;
                    r_state <= StAfW;
                end
                StAfW: begin
                    if (r_cnt == C_RC) begin
                        if (r_af_cnt == C_AF) begin
                            r_init_done <= 1'b1;
                            r_busy      <= 1'b0;
                            r_dqm       <= DQM_RUN;
                            r_state     <= StIdle;
                        end else begin
                            r_cmd    <= CMD_REF;
                            r_af_cnt <= r_af_cnt + 4'd1;
                            r_state  <= StAf;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StIdle: begin
                    if (ref_gnt && w_ref_req) begin
                        r_busy    <= 1'b1;
                        r_consume <= 1'b1;
                        r_state   <= StRpre;
                    end
                end
                // Hand-over cycle: pins are ours from here, PRE goes out on exit
                StRpre: begin
                    r_cnt   <= '0;
                    r_cmd   <= CMD_PRE;
                    r_state <= StRpreW;
                end
                StRpreW: begin
                    if (r_cnt == C_RRP) begin
                        r_cmd   <= CMD_REF;
                        r_state <= StRaf;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StRaf: begin
                    r_cnt   <= '0;
                    r_state <= StRafW;
                end
                StRafW: begin
                    if (r_cnt == C_RC) begin
                        r_busy     <= 1'b0;
                        r_ref_done <= 1'b1;
                        r_state    <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= StWait;
                end
            endcase
        end
    end

    sdram_ref_timer #(
        .REF_INTERVAL (REF_INTERVAL)
    ) u_ref_timer (
        .i_clk      (REF_CLK),
        .i_rst_n    (RST_N),
        .i_en       (r_init_done),
        .i_consume  (r_consume),
        .o_ref_req  (w_ref_req),
        .o_ref_miss (w_ref_miss)
    );

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Self-checking bench for sdram_init_refresh: cycle-accurate schedule model
// derived from the timing rules, randomized grants, directed corner cases.
module tb_sdram_init_refresh;

    localparam int T_INIT   = 100;
    localparam int T_RP     = 2;
    localparam int T_MRD    = 2;
    localparam int T_RC     = 7;
    localparam int N_AF     = 8;
    localparam int RI       = 200;
    localparam int INIT_END = T_INIT + 1 + T_RP + T_MRD + N_AF * T_RC;
    localparam int REF_LEN  = 1 + T_RP + T_RC;

    localparam logic [3:0]  NOP = 4'b0111;
    localparam logic [3:0]  PRE = 4'b0010;
    localparam logic [3:0]  MRS = 4'b0000;
    localparam logic [3:0]  REF = 4'b0001;
    // WB=0, CAS=3, BT=0, BL=7
    localparam logic [12:0] MODE_A = 13'((0 << 9) | (3 << 4) | (0 << 3) | 7);

    logic        REF_CLK = 1'b0;
    logic        RST_N   = 1'b0;
    logic        ref_gnt = 1'b0;
    logic        CKE, CS_N, RAS_N, CAS_N, WE_N;
    logic [12:0] A;
    logic [1:0]  BS;
    logic [1:0]  DQM;
    logic        init_done, busy, ref_req, ref_done, ref_miss;

    int checks = 0;
    int errors = 0;
    int e      = 0;  // rising edges since reset release
    int g_edge = -1; // edge of the latest accepted grant
    int owed   = 0;  // outstanding refresh obligations
    bit miss   = 1'b0;

    sdram_init_refresh #(
        .T_INIT       (T_INIT),
        .T_RP         (T_RP),
        .T_MRD        (T_MRD),
        .T_RC         (T_RC),
        .INIT_AF_CNT  (N_AF),
        .REF_INTERVAL (RI),
        .ROW_W        (13),
        .BANK_W       (2),
        .CAS_LAT      (3'b011),
        .BURST_TYPE   (1'b0),
        .BL_CODE      (3'b111),
        .WB_MODE      (1'b0)
    ) dut (
        .REF_CLK   (REF_CLK),
        .RST_N     (RST_N),
        .CKE       (CKE),
        .CS_N      (CS_N),
        .RAS_N     (RAS_N),
        .CAS_N     (CAS_N),
        .WE_N      (WE_N),
        .A         (A),
        .BS        (BS),
        .DQM       (DQM),
        .init_done (init_done),
        .busy      (busy),
        .ref_req   (ref_req),
        .ref_gnt   (ref_gnt),
        .ref_done  (ref_done),
        .ref_miss  (ref_miss)
    );

    always #5 REF_CLK = ~REF_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%h expected=%h", tag, e, obs, exp);
        end
    endtask

    // Advance the obligation/grant model by one edge given the grant seen at it
    task automatic model(input logic gnt);
        bit idle_prev, accept, tick, consume;
        idle_prev = (e - 1 >= INIT_END) && (g_edge < 0 || e - 1 >= g_edge + REF_LEN);
        accept    = idle_prev && (owed != 0) && gnt;
        tick      = (e > INIT_END) && ((e - INIT_END) % RI == 0);
        consume   = (g_edge >= 0) && (e == g_edge + 1);
        if (accept) g_edge = e;
`ifdef SDRAM_REF_DEBT_EN
        if (tick && !consume) begin
            if (owed == 8) miss = 1'b1;
            else owed++;
        end else if (consume && !tick && owed > 0) begin
            owed--;
        end
`else
        if (tick && !consume) begin
            if (owed != 0) miss = 1'b1;
            owed = 1;
        end else if (consume && !tick) begin
            owed = 0;
        end
`endif
    endtask

    task automatic check_now();
        logic [3:0]  cmd;
        logic [12:0] a;
        logic [1:0]  bs;
        logic [1:0]  dqm;
        logic        busy_e, done_e;
        int          af0;
        cmd = NOP;
        a   = '1;
        bs  = '1;
        af0 = T_INIT + 1 + T_RP + T_MRD;
        if (e < INIT_END) begin
            if (e == T_INIT + 1) cmd = PRE;
            else if (e == T_INIT + 1 + T_RP) cmd = MRS;
            else if (e >= af0 && (e - af0) % T_RC == 0 && (e - af0) / T_RC < N_AF) cmd = REF;
        end else if (g_edge >= 0) begin
            if (e == g_edge + 1) cmd = PRE;
            else if (e == g_edge + 1 + T_RP) cmd = REF;
        end
        if (cmd == MRS) begin
            a  = MODE_A;
            bs = 2'b00;
        end
        dqm    = (e >= INIT_END) ? 2'b00 : 2'b11;
        busy_e = (e < INIT_END) || (g_edge >= 0 && e < g_edge + REF_LEN);
        done_e = (g_edge >= 0) && (e == g_edge + REF_LEN);
        chk("pins", 32'({CKE, CS_N, RAS_N, CAS_N, WE_N, A, BS, DQM}),
            32'({1'b1, cmd, a, bs, dqm}));
        chk("flags", 32'({init_done, busy, ref_req, ref_done, ref_miss}),
            32'({(e >= INIT_END), busy_e, (owed != 0), done_e, miss}));
    endtask

    task automatic step();
        logic gnt;
        gnt = ref_gnt;
        @(posedge REF_CLK);
        e++;
        model(gnt);
        #1;
        check_now();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_pins"}, 32'({CKE, CS_N, RAS_N, CAS_N, WE_N, A, BS, DQM}),
            32'({1'b0, 4'b1111, 13'h1fff, 2'b11, 2'b11}));
        chk({tag, "_flags"}, 32'({init_done, busy, ref_req, ref_done, ref_miss}),
            32'(5'b01000));
    endtask

    initial begin
        bit found;
        bit exp_miss;
`ifdef SDRAM_REF_DEBT_EN
        exp_miss = 1'b0;
`else
        exp_miss = 1'b1;
`endif
        repeat (3) @(posedge REF_CLK);
        #1;
        check_reset("reset");
        @(negedge REF_CLK);
        RST_N = 1'b1;
        e = 0;

        // Init sequence with random grants that must all be ignored
        while (e < INIT_END + 5) begin
            ref_gnt = 1'($urandom_range(0, 1));
            step();
            if (e == T_INIT + 1 + T_RP) chk("mrs_addr", 32'(A), 32'(MODE_A));
            if (e == INIT_END) chk("init_done_edge", 32'(init_done), 32'(1));
        end
        ref_gnt = 1'b0;

        // First tick, grant 5 cycles later
        while (e < INIT_END + RI) step();
        chk("tick_req", 32'(ref_req), 32'(1));
        repeat (4) step();
        ref_gnt = 1'b1;
        step();
        ref_gnt = 1'b0;
        chk("g1_busy", 32'(busy), 32'(1));
        step();
        chk("g1_pre", 32'({CS_N, RAS_N, CAS_N, WE_N}), 32'(PRE));
        chk("g1_req_low", 32'(ref_req), 32'(0));
        while (e < g_edge + REF_LEN) step();
        chk("g1_done", 32'(ref_done), 32'(1));

        // Withhold grant across two ticks, then drain
        while (e < INIT_END + 3 * RI) step();
        chk("withhold_miss", 32'(ref_miss), 32'(exp_miss));
        chk("withhold_req", 32'(ref_req), 32'(1));
        ref_gnt = 1'b1;
        repeat (30) step();
        ref_gnt = 1'b0;
        chk("drain_req", 32'(ref_req), 32'(0));

        // Randomized grant traffic
        repeat (1500) begin
            ref_gnt = ($urandom_range(0, 3) == 0);
            step();
        end

        // Reset in the middle of a refresh's RAF_W phase
        ref_gnt = 1'b1;
        found   = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step();
            if (g_edge >= 0 && e == g_edge + 5) found = 1'b1;
        end
        chk("raf_w_reached", 32'(found), 32'(1));
        #2;
        RST_N = 1'b0;
        #1;
        check_reset("async_reset");
        ref_gnt = 1'b0;
        @(posedge REF_CLK);
        #1;
        check_reset("reset_hold");
        @(negedge REF_CLK);
        RST_N  = 1'b1;
        e      = 0;
        g_edge = -1;
        owed   = 0;
        miss   = 1'b0;
        while (e < T_INIT + 3) begin
            ref_gnt = 1'($urandom_range(0, 1));
            step();
            if (e == T_INIT + 1) chk("pre_after_reset", 32'({CS_N, RAS_N, CAS_N, WE_N}), 32'(PRE));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
